packet_framer: RTL and testbench

PACKET_FRAMER -- requirements
Module: packet_framer

---
 rtl/packet_framer.sv | 101 ++++++++++
 tb/tb_packet_framer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/packet_framer.sv
// packet_framer: serialises a command header plus 32-bit payload words into a byte stream
// Ports: clk_i/rst_i clock and sync active-high reset; cmd_* command handshake (opcode, word count);
// word_* payload word handshake; tx_* byte stream to the TX FIFO; busy_o high while a packet is in flight.
module packet_framer #(
  parameter int WORD_WIDTH_P = 32,
  parameter int MAX_WORDS_P = 15
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [7:0]                         cmd_opcode_i,
  input  logic [$clog2(MAX_WORDS_P+1)-1:0]   cmd_nwords_i,
  input  logic                               word_valid_i,
  output logic                               word_ready_o,
  input  logic [WORD_WIDTH_P-1:0]            word_data_i,
  output logic                               tx_valid_o,
  input  logic                               tx_ready_i,
  output logic [7:0]                         tx_data_o,
  output logic                               busy_o
);
  localparam int NW_W = $clog2(MAX_WORDS_P + 1);
  typedef enum logic [1:0] {IDLE, HDR, WORD, PAY} state_e;
  state_e state_q, state_d;
  logic tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [NW_W-1:0] rem_q, rem_d;
  logic [1:0] idx_q, idx_d;
  logic [WORD_WIDTH_P-1:0] word_q, word_d;
  logic tx_hs;
  logic [1:0] idx_n;
  logic [7:0] len;
  assign tx_hs = tx_valid_q && tx_ready_i;
  assign idx_n = idx_q + 2'd1;
  // rem_q still holds the full word count while the header is going out
  assign len = 8'((32'(rem_q) + 32'd1) << 2);
  assign cmd_ready_o = state_q == IDLE;
  assign word_ready_o = state_q == WORD;
  assign busy_o = state_q != IDLE;
  assign tx_valid_o = tx_valid_q;
  assign tx_data_o = tx_data_q;
  always_comb begin
    state_d = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d = tx_data_q;
    rem_d = rem_q;
    idx_d = idx_q;
    word_d = word_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        rem_d = cmd_nwords_i;
        idx_d = 2'd0;
        tx_valid_d = 1'b1;
        tx_data_d = cmd_opcode_i;
        state_d = HDR;
      end
      HDR: if (tx_hs) begin
        idx_d = idx_n;
        tx_data_d = idx_n == 2'd2 ? len : 8'h00;
        if (idx_q == 2'd3) begin
          tx_valid_d = 1'b0;
          state_d = rem_q != '0 ? WORD : IDLE;
        end
      end
      WORD: if (word_valid_i) begin
        word_d = word_data_i;
        idx_d = 2'd0;
        tx_valid_d = 1'b1;
        tx_data_d = word_data_i[7:0];
        state_d = PAY;
      end
      PAY: if (tx_hs) begin
        idx_d = idx_n;
        tx_data_d = 8'(word_q >> {idx_n, 3'b000});
        if (idx_q == 2'd3) begin
          tx_valid_d = 1'b0;
          rem_d = rem_q - NW_W'(1);
          state_d = rem_q != NW_W'(1) ? WORD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q <= 8'h00;
      rem_q <= '0;
      idx_q <= 2'd0;
      word_q <= '0;
    end else begin
      state_q <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q <= tx_data_d;
      rem_q <= rem_d;
      idx_q <= idx_d;
      word_q <= word_d;
    end
  end
endmodule

// File: tb/tb_packet_framer.sv
// tb_packet_framer: scoreboard bench for packet_framer
module tb_packet_framer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic cmd_valid_i = 1'b0;
  logic cmd_ready_o;
  logic [7:0] cmd_opcode_i = 8'h00;
  logic [3:0] cmd_nwords_i = 4'd0;
  logic word_valid_i = 1'b0;
  logic word_ready_o;
  logic [31:0] word_data_i = 32'h0;
  logic tx_valid_o;
  logic tx_ready_i = 1'b1;
  logic [7:0] tx_data_o;
  logic busy_o;
  packet_framer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_nwords_i(cmd_nwords_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_data_i(word_data_i),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
    .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  int n_chk = 0, n_err = 0;
  int acc_cnt = 0, word_cnt = 0, tx_cnt = 0, idle_cnt = 0, cyc = 0;
  logic rnd = 1'b0;
  logic word_f = 1'b0, stall_f = 1'b0;
  logic [7:0] stall_d = 8'h00;
  logic s_valid = 1'b0, s_busy = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic [7:0] exp_q[$];
  logic [31:0] wq[$];
  logic [31:0] nxt[$];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk_i);
    s_valid = tx_valid_o;
    s_data = tx_data_o;
    s_busy = busy_o;
    word_f = word_valid_i && word_ready_o && !rst_i;
    if (word_f) word_cnt++;
    if (cmd_valid_i && cmd_ready_o && !rst_i) acc_cnt++;
    if (!rst_i && !busy_o) idle_cnt++;
    if (stall_f && !rst_i) begin
      chk("stall_valid", 32'(tx_valid_o), 32'd1);
      chk("stall_data", 32'(tx_data_o), 32'(stall_d));
    end
    if (!rst_i && tx_valid_o && tx_ready_i) begin
      tx_cnt++;
      if (exp_q.size() == 0) chk("tx_extra", 32'(exp_q.size()), 32'd1);
      else chk("tx_byte", 32'(tx_data_o), 32'(exp_q.pop_front()));
    end
    stall_f = tx_valid_o && !tx_ready_i && !rst_i;
    stall_d = tx_data_o;
    @(posedge clk_i);
    #1;
    if (word_f) void'(wq.pop_front());
    word_valid_i = wq.size() > 0;
    word_data_i = wq.size() > 0 ? wq[0] : 32'h0;
    tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc++;
  endtask
  task automatic add_pkt(input logic [7:0] op, input int n);
    logic [31:0] w;
    exp_q.push_back(op);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(4 + 4 * n));
    exp_q.push_back(8'h00);
    for (int i = 0; i < n; i++) begin
      w = nxt.size() > 0 ? nxt.pop_front() : $urandom();
      for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
      wq.push_back(w);
    end
  endtask
  task automatic wait_acc(input int target);
    int t = 0;
    while (acc_cnt < target && t < 100) begin
      step();
      t++;
    end
    chk("cmd_accept", 32'(acc_cnt), 32'(target));
  endtask
  task automatic wait_idle();
    int t = 0;
    do begin
      step();
      t++;
    end while (s_busy && t < 3000);
    chk("busy_end", 32'(s_busy), 32'd0);
  endtask
  task automatic send(input logic [7:0] op, input int n, input logic r);
    int w0, t0, c0;
    rnd = r;
    add_pkt(op, n);
    cmd_opcode_i = op;
    cmd_nwords_i = 4'(n);
    cmd_valid_i = 1'b1;
    w0 = word_cnt;
    t0 = tx_cnt;
    wait_acc(acc_cnt + 1);
    cmd_valid_i = 1'b0;
    c0 = cyc;
    step();
    chk("hdr_valid", 32'(s_valid), 32'd1);
    chk("hdr_opcode", 32'(s_data), 32'(op));
    wait_idle();
    if (!r) chk("pkt_cycles", 32'(cyc - c0), 32'(5 + 5 * n));
    chk("word_hs", 32'(word_cnt - w0), 32'(n));
    chk("byte_hs", 32'(tx_cnt - t0), 32'(4 + 4 * n));
    chk("exp_left", 32'(exp_q.size()), 32'd0);
  endtask
  initial begin
    int a0, i0, t, t0;
    step();
    step();
    chk("rst_valid", 32'(tx_valid_o), 32'd0);
    chk("rst_data", 32'(tx_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_word_ready", 32'(word_ready_o), 32'd0);
    rst_i = 1'b0;
    step();
    send(8'h10, 0, 1'b0);
    nxt.push_back(32'h04030201);
    nxt.push_back(32'hDEADBEEF);
    send(8'h20, 2, 1'b0);
    nxt.push_back(32'h04030201);
    nxt.push_back(32'hDEADBEEF);
    send(8'h20, 2, 1'b1);
    send(8'h5A, 15, 1'b0);
    for (int k = 0; k < 4; k++) send(8'($urandom()), int'($urandom_range(0, 15)), 1'b1);
    rnd = 1'b0;
    exp_q = '{8'h40, 8'h00, 8'h08, 8'h00, 8'hA4, 8'hA3, 8'hA2};
    wq.push_back(32'hA1A2A3A4);
    cmd_opcode_i = 8'h40;
    cmd_nwords_i = 4'd1;
    cmd_valid_i = 1'b1;
    wait_acc(acc_cnt + 1);
    cmd_valid_i = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      step();
      t++;
    end
    chk("pre_rst_bytes", 32'(exp_q.size()), 32'd0);
    t0 = tx_cnt;
    rst_i = 1'b1;
    step();
    chk("mid_rst_valid", 32'(tx_valid_o), 32'd0);
    chk("mid_rst_data", 32'(tx_data_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("mid_rst_word_ready", 32'(word_ready_o), 32'd0);
    rst_i = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("post_rst_silent", 32'(tx_cnt - t0), 32'd0);
    send(8'h30, 0, 1'b0);
    nxt.push_back($urandom());
    add_pkt(8'h50, 1);
    add_pkt(8'h51, 0);
    a0 = acc_cnt;
    cmd_opcode_i = 8'h50;
    cmd_nwords_i = 4'd1;
    cmd_valid_i = 1'b1;
    wait_acc(a0 + 1);
    cmd_opcode_i = 8'h51;
    cmd_nwords_i = 4'd0;
    i0 = idle_cnt;
    wait_acc(a0 + 2);
    cmd_valid_i = 1'b0;
    chk("b2b_gap", 32'(idle_cnt - i0), 32'd1);
    wait_idle();
    chk("b2b_exp_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
